// File: rtl/pwm_capture_if.sv
// Measurement result channel of pwm_capture: valid/ready handshake plus data and status flags.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] m_period;
    logic [CNT_W-1:0] m_high;
    logic             m_timeout;
    logic             m_overrun;

    modport master (
        output m_valid, m_period, m_high, m_timeout, m_overrun,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_period, m_high, m_timeout, m_overrun,
        output m_ready
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM period / high-time meter with valid/ready result channel.
// Optional glitch filter on the synchronized input: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W  = 16,
    parameter int FILT_N = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    pwm_capture_if.master m
);

    if (CNT_W < 4 || FILT_N < 1) begin : g_param_check
        $error("pwm_capture: CNT_W must be >= 4 and FILT_N >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        STUCK
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_q, s2_q, s3_q;
    logic             lvl, rise;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             report;
    logic [CNT_W-1:0] rep_period, rep_high;
    logic             rep_timeout;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= lvl;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FC_W = (FILT_N > 1) ? $clog2(FILT_N) : 1;

    logic            filt_q;
    logic [FC_W-1:0] fcnt_q;

    // fcnt_q counts consecutive s2 samples that disagree with the filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (s2_q == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FC_W'(FILT_N - 1)) begin
            filt_q <= s2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + FC_W'(1);
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s2_q;
`endif

    assign rise = lvl & ~s3_q;

    always_comb begin
        state_d     = state_q;
        report      = 1'b0;
        rep_period  = pcnt_q;
        rep_high    = hcnt_q;
        rep_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    report = 1'b1;
                end else if (pcnt_q == CNT_MAX) begin
                    report      = 1'b1;
                    rep_period  = CNT_MAX;
                    rep_high    = lvl ? CNT_MAX : '0;
                    rep_timeout = 1'b1;
                    state_d     = STUCK;
                end
            end
            STUCK: begin
                if (rise) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pcnt_d = pcnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            pcnt_d = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end else if (state_q != STUCK) begin
            if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_W'(1);
            if (lvl && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_W'(1);
        end
    end

    // A new report always wins over a handshake; overrun only when unconsumed data is replaced
    always_comb begin
        valid_d   = valid_q;
        period_d  = period_q;
        high_d    = high_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        if (report) begin
            valid_d   = 1'b1;
            period_d  = rep_period;
            high_d    = rep_high;
            timeout_d = rep_timeout;
            overrun_d = valid_q & ~m.m_ready;
        end else if (valid_q && m.m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            valid_q   <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            hcnt_q    <= hcnt_d;
            valid_q   <= valid_d;
            period_q  <= period_d;
            high_q    <= high_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign m.m_valid   = valid_q;
    assign m.m_period  = period_q;
    assign m.m_high    = high_q;
    assign m.m_timeout = timeout_q;
    assign m.m_overrun = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a 16-bit and an 8-bit instance share one PWM pin,
// and an edge-timestamp model predicts every report from the pin waveform.
module tb_pwm_capture;

    localparam int unsigned FN = 3;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int unsigned LAT = 2 + FN;
`else
    localparam int unsigned LAT = 2;
`endif

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] high;
        logic        timeout;
        logic        overrun;
        logic [31:0] cyc;
    } rep_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pwm_in;
    logic rdy;

    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_W(16)) bus16 ();
    pwm_capture_if #(.CNT_W(8))  bus8  ();

    assign bus16.m_ready = rdy;
    assign bus8.m_ready  = rdy;

    pwm_capture #(.CNT_W(16), .FILT_N(FN)) dut16 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .m(bus16)
    );
    pwm_capture #(.CNT_W(8), .FILT_N(FN)) dut8 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .m(bus8)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned vcnt16 = 0;
    int unsigned vcnt8 = 0;
    rep_t exp16[$], exp8[$], obs16[$], obs8[$];

    // Reference model: reports are derived from pin rise timestamps and a running
    // count of high cycles; index 0 models CNT_W=16, index 1 models CNT_W=8.
    logic        prev_lvl = 1'b0;
    bit          armed [2];
    int unsigned last_rise [2];
    int unsigned hmark [2];
    int unsigned high_total = 0;
    int unsigned maxv [2] = '{65535, 255};

    always @(posedge clk) begin
        rep_t r;
        logic lv;
        bit   rz;
        bit   has;
        cyc = cyc + 1;
        if (!rst_n) begin
            prev_lvl = 1'b0;
            armed[0] = 0;
            armed[1] = 0;
            exp16.delete();
            exp8.delete();
        end else begin
            lv = pwm_in;
            rz = lv && !prev_lvl;
            for (int w = 0; w < 2; w++) begin
                r   = '0;
                has = 0;
                if (rz) begin
                    if (armed[w]) begin
                        r.period = 16'(cyc - last_rise[w]);
                        r.high   = 16'(high_total - hmark[w]);
                        r.cyc    = cyc + LAT;
                        has      = 1;
                    end
                    armed[w]     = 1;
                    last_rise[w] = cyc;
                    hmark[w]     = high_total;
                end else if (armed[w] && (cyc - last_rise[w]) == maxv[w]) begin
                    r.period  = 16'(maxv[w]);
                    r.high    = lv ? 16'(maxv[w]) : 16'd0;
                    r.timeout = 1'b1;
                    r.cyc     = cyc + LAT;
                    has       = 1;
                    armed[w]  = 0;
                end
                if (has) begin
                    if (w == 0) exp16.push_back(r);
                    else        exp8.push_back(r);
                end
            end
            if (lv) high_total = high_total + 1;
            prev_lvl = lv;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            obs16.delete();
            obs8.delete();
            vcnt16 = 0;
            vcnt8  = 0;
        end else begin
            if (bus16.m_valid) vcnt16++;
            if (bus8.m_valid) vcnt8++;
            if (bus16.m_valid && bus16.m_ready)
                obs16.push_back(rep_t'({bus16.m_period, bus16.m_high, bus16.m_timeout,
                                        bus16.m_overrun, cyc}));
            if (bus8.m_valid && bus8.m_ready)
                obs8.push_back(rep_t'({8'h00, bus8.m_period, 8'h00, bus8.m_high,
                                       bus8.m_timeout, bus8.m_overrun, cyc}));
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic drive_period(input int unsigned p, input int unsigned h);
        pwm_in = 1'b1;
        cycles(h);
        pwm_in = 1'b0;
        cycles(p - h);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        rdy    = 1'b0;
        cycles(2);
        n_cmp++;
        if ({bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun} !== '0) begin
            n_bad++;
            $display("FAIL reset16: got v=%b p=%0d h=%0d to=%b ov=%b, want all 0",
                     bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun);
        end
        n_cmp++;
        if ({bus8.m_valid, bus8.m_period, bus8.m_high, bus8.m_timeout, bus8.m_overrun} !== '0) begin
            n_bad++;
            $display("FAIL reset8: got v=%b p=%0d h=%0d to=%b ov=%b, want all 0",
                     bus8.m_valid, bus8.m_period, bus8.m_high, bus8.m_timeout, bus8.m_overrun);
        end
        rst_n = 1'b1;
        cycles(50);
        n_cmp++;
        if (vcnt16 != 0 || vcnt8 != 0) begin
            n_bad++;
            $display("FAIL idle_valid: got valid cycles %0d/%0d, want 0/0", vcnt16, vcnt8);
        end
    endtask

    task automatic test_square();
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) drive_period(10, 3);
        pwm_in = 1'b1;
        cycles(3);
        pwm_in = 1'b0;
        cycles(10);
        n_cmp++;
        if (obs16.size() != 8 || exp16.size() != 8) begin
            n_bad++;
            $display("FAIL square_count: got %0d reports (model %0d), want 8", obs16.size(), exp16.size());
        end
        for (int i = 0; i < obs16.size() && i < exp16.size(); i++) begin
            n_cmp++;
            if (obs16[i] !== exp16[i] || obs16[i].period != 16'd10 || obs16[i].high != 16'd3) begin
                n_bad++;
                $display("FAIL square_rep[%0d]: got p=%0d h=%0d to=%b ov=%b t=%0d, want p=%0d h=%0d to=%b ov=%b t=%0d",
                         i, obs16[i].period, obs16[i].high, obs16[i].timeout, obs16[i].overrun, obs16[i].cyc,
                         exp16[i].period, exp16[i].high, exp16[i].timeout, exp16[i].overrun, exp16[i].cyc);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        rdy = 1'b0;
        drive_period(20, 5);
        for (int k = 1; k <= 3; k++) begin
            drive_period(20, 5);
            n_cmp++;
            if ({bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun}
                    !== {1'b1, 16'd20, 16'd5, 1'b0, (k > 1)}) begin
                n_bad++;
                $display("FAIL overrun_rep%0d: got v=%b p=%0d h=%0d to=%b ov=%b, want v=1 p=20 h=5 to=0 ov=%0d",
                         k, bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun, k > 1);
            end
        end
        rdy = 1'b1;
        cycles(1);
        rdy = 1'b0;
        n_cmp++;
        if ({bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_overrun} !== {1'b0, 16'd20, 16'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL overrun_ack: got v=%b p=%0d h=%0d ov=%b, want v=0 p=20 h=5 ov=1",
                     bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_overrun);
        end
        // rise-to-rise gap includes the one handshake cycle
        drive_period(20, 5);
        n_cmp++;
        if ({bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun}
                !== {1'b1, 16'd21, 16'd5, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL overrun_clear: got v=%b p=%0d h=%0d to=%b ov=%b, want v=1 p=21 h=5 to=0 ov=0",
                     bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) drive_period(15, 4);
        n_cmp++;
        if ({bus16.m_valid, bus16.m_overrun} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_pre: got v=%b ov=%b, want v=1 ov=1", bus16.m_valid, bus16.m_overrun);
        end
        pwm_in = 1'b1;
        cycles(LAT);
        rdy = 1'b1;
        cycles(1);
        rdy = 1'b0;
        n_cmp++;
        if ({bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun}
                !== {1'b1, 16'd15, 16'd4, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_same_cycle: got v=%b p=%0d h=%0d to=%b ov=%b, want v=1 p=15 h=4 to=0 ov=0",
                     bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun);
        end
        cycles(4 - (LAT + 1) % 4);
        pwm_in = 1'b0;
        cycles(10);
        rdy = 1'b1;
        cycles(1);
        rdy = 1'b0;
        n_cmp++;
        if (bus16.m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ack: got v=%b, want v=0", bus16.m_valid);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        rdy = 1'b1;
        drive_period(255, 100);
        drive_period(50, 5);
        pwm_in = 1'b1;
        cycles(300);
        pwm_in = 1'b0;
        cycles(20);
        drive_period(40, 10);
        pwm_in = 1'b1;
        cycles(5);
        pwm_in = 1'b0;
        cycles(300);
        n_cmp++;
        if (obs8.size() != exp8.size() || obs8.size() != 5) begin
            n_bad++;
            $display("FAIL timeout_count: got %0d reports (model %0d), want 5", obs8.size(), exp8.size());
        end
        for (int i = 0; i < obs8.size() && i < exp8.size(); i++) begin
            n_cmp++;
            if (obs8[i] !== exp8[i]) begin
                n_bad++;
                $display("FAIL timeout_rep[%0d]: got p=%0d h=%0d to=%b ov=%b t=%0d, want p=%0d h=%0d to=%b ov=%b t=%0d",
                         i, obs8[i].period, obs8[i].high, obs8[i].timeout, obs8[i].overrun, obs8[i].cyc,
                         exp8[i].period, exp8[i].high, exp8[i].timeout, exp8[i].overrun, exp8[i].cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) drive_period(10, 3);
        pwm_in = 1'b1;
        cycles(3);
        pwm_in = 1'b0;
        cycles(3);
        rst_n = 1'b0;
        cycles(1);
        n_cmp++;
        if ({bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun} !== '0) begin
            n_bad++;
            $display("FAIL midreset: got v=%b p=%0d h=%0d to=%b ov=%b, want all 0",
                     bus16.m_valid, bus16.m_period, bus16.m_high, bus16.m_timeout, bus16.m_overrun);
        end
        cycles(1);
        rst_n = 1'b1;
        cycles(4);
        drive_period(12, 4);
        drive_period(12, 4);
        pwm_in = 1'b1;
        cycles(4);
        pwm_in = 1'b0;
        cycles(10);
        n_cmp++;
        if (obs16.size() != exp16.size() || obs16.size() != 2) begin
            n_bad++;
            $display("FAIL midreset_count: got %0d reports (model %0d), want 2", obs16.size(), exp16.size());
        end
        for (int i = 0; i < obs16.size() && i < exp16.size(); i++) begin
            n_cmp++;
            if (obs16[i] !== exp16[i]) begin
                n_bad++;
                $display("FAIL midreset_rep[%0d]: got p=%0d h=%0d to=%b ov=%b t=%0d, want p=%0d h=%0d to=%b ov=%b t=%0d",
                         i, obs16[i].period, obs16[i].high, obs16[i].timeout, obs16[i].overrun, obs16[i].cyc,
                         exp16[i].period, exp16[i].high, exp16[i].timeout, exp16[i].overrun, exp16[i].cyc);
            end
        end
    endtask

    task automatic test_random();
        int unsigned p, h;
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
`ifdef PWM_CAPTURE_FILTER_EN
            p = $urandom_range(60, 2 * FN + 2);
            h = $urandom_range(p - FN, FN);
`else
            p = $urandom_range(60, 4);
            h = $urandom_range(p - 1, 1);
`endif
            drive_period(p, h);
        end
        pwm_in = 1'b1;
        cycles(FN + 1);
        pwm_in = 1'b0;
        cycles(20);
        n_cmp++;
        if (obs16.size() != exp16.size() || obs16.size() != 30) begin
            n_bad++;
            $display("FAIL random_count: got %0d reports (model %0d), want 30", obs16.size(), exp16.size());
        end
        for (int i = 0; i < obs16.size() && i < exp16.size(); i++) begin
            n_cmp++;
            if (obs16[i] !== exp16[i]) begin
                n_bad++;
                $display("FAIL random_rep[%0d]: got p=%0d h=%0d to=%b ov=%b t=%0d, want p=%0d h=%0d to=%b ov=%b t=%0d",
                         i, obs16[i].period, obs16[i].high, obs16[i].timeout, obs16[i].overrun, obs16[i].cyc,
                         exp16[i].period, exp16[i].high, exp16[i].timeout, exp16[i].overrun, exp16[i].cyc);
            end
        end
    endtask

`ifdef PWM_CAPTURE_FILTER_EN
    task automatic test_glitch();
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pwm_in = 1'b1;
            cycles(6);
            pwm_in = 1'b0;
            cycles(3);
            pwm_in = 1'b1;
            cycles(2);
            pwm_in = 1'b0;
            cycles(5);
        end
        pwm_in = 1'b1;
        cycles(6);
        pwm_in = 1'b0;
        cycles(15);
        n_cmp++;
        if (obs16.size() != 5) begin
            n_bad++;
            $display("FAIL glitch_count: got %0d reports, want 5", obs16.size());
        end
        for (int i = 0; i < obs16.size(); i++) begin
            n_cmp++;
            if ({obs16[i].period, obs16[i].high, obs16[i].timeout, obs16[i].overrun}
                    !== {16'd16, 16'd6, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL glitch_rep[%0d]: got p=%0d h=%0d to=%b ov=%b, want p=16 h=6 to=0 ov=0",
                         i, obs16[i].period, obs16[i].high, obs16[i].timeout, obs16[i].overrun);
            end
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        rdy    = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_square();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
`ifdef PWM_CAPTURE_FILTER_EN
        test_glitch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
